// File: rtl/duty_gen_pkg.sv
// Shared types and constants for the multi-channel duty-cycle generator.
// Holds the configuration engine state encoding and the duty/period limits.
package duty_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int DUTY_W     = 7;
    localparam int MAX_DUTY   = 100;
    localparam int MIN_PERIOD = 2;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
        return (duty > DUTY_W'(MAX_DUTY)) ? DUTY_W'(MAX_DUTY) : duty;
    endfunction

endpackage

// File: rtl/duty_ton_calc.sv
// Sequential ton = floor(period*duty/100): restoring divider, one quotient bit per cycle.
// done is high on the cycle the final quotient bit is resolved; ton is valid the cycle after.
module duty_ton_calc
    import duty_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  period,
    input  logic [DUTY_W-1:0] duty,
    output logic              done,
    output logic [CNT_W-1:0]  ton
);

    localparam int QW    = CNT_W + DUTY_W;
    localparam int BW    = $clog2(QW + 1);
    localparam int REM_W = DUTY_W;
    localparam logic [REM_W:0] DIVISOR = (REM_W + 1)'(MAX_DUTY);

    logic              busy_q, busy_d;
    logic [BW-1:0]     step_q, step_d;
    logic [QW-1:0]     work_q, work_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [REM_W:0]    rem_sh;
    logic              q_bit;

    // The dividend shifts out of work_q's MSB while quotient bits shift in at the LSB.
    always_comb begin
        busy_d = busy_q;
        step_d = step_q;
        work_d = work_q;
        rem_d  = rem_q;
        rem_sh = {rem_q, work_q[QW-1]};
        q_bit  = (rem_sh >= DIVISOR);
        if (start) begin
            busy_d = 1'b1;
            step_d = BW'(QW);
            work_d = QW'(period) * QW'(duty);
            rem_d  = '0;
        end else if (busy_q) begin
            work_d = {work_q[QW-2:0], q_bit};
            rem_d  = q_bit ? REM_W'(rem_sh - DIVISOR) : rem_sh[REM_W-1:0];
            step_d = step_q - BW'(1);
            busy_d = (step_q != BW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            step_q <= '0;
            work_q <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            step_q <= step_d;
            work_q <= work_d;
            rem_q  <= rem_d;
        end
    end

    assign done = busy_q && (step_q == BW'(1));
    // Quotient never exceeds period; the saturate keeps the narrowing explicit.
    assign ton  = (|work_q[QW-1:CNT_W]) ? '1 : work_q[CNT_W-1:0];

endmodule

// File: rtl/duty_gen_mc.sv
// NUM_CH independent duty-cycle outputs sharing one config engine that turns
// (period, duty%) into (period, ton) and double-buffers it into the channel.
//   state    | meaning
//   ST_IDLE  | cfg_ready high, waiting for cfg_valid
//   ST_CALC  | divider resolving ton, one bit per cycle
//   ST_WRITE | load pending {period, ton} into the target channel
module duty_gen_mc
    import duty_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] wrap
);

    state_t             state_q;
    logic               cfg_ready_q;
    logic [CH_W-1:0]    calc_ch_q;
    logic [CNT_W-1:0]   calc_period_q;
    logic [CNT_W-1:0]   period_c;
    logic [DUTY_W-1:0]  duty_c;
    logic [CNT_W-1:0]   calc_ton;
    logic               calc_done;
    logic               accept;
    logic               write_en;

    always_comb begin
        period_c = cfg_period;
        if (cfg_period < CNT_W'(MIN_PERIOD)) begin
            period_c = CNT_W'(MIN_PERIOD);
        end
        duty_c = clamp_duty(cfg_duty);
    end

    assign accept    = cfg_valid && cfg_ready_q;
    assign write_en  = (state_q == ST_WRITE);
    assign cfg_ready = cfg_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cfg_ready_q   <= 1'b1;
            calc_ch_q     <= '0;
            calc_period_q <= CNT_W'(MIN_PERIOD);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q       <= ST_CALC;
                        cfg_ready_q   <= 1'b0;
                        calc_ch_q     <= cfg_ch;
                        calc_period_q <= period_c;
                    end
                end
                ST_CALC: begin
                    if (calc_done) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    duty_ton_calc #(
        .CNT_W (CNT_W)
    ) u_calc (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .period (period_c),
        .duty   (duty_c),
        .done   (calc_done),
        .ton    (calc_ton)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_period_q, act_period_d;
        logic [CNT_W-1:0] act_ton_q, act_ton_d;
        logic [CNT_W-1:0] pend_period_q, pend_period_d;
        logic [CNT_W-1:0] pend_ton_q, pend_ton_d;
        logic             pend_q, pend_d;
        logic             run_q, run_d;
        logic             clk_out_q, clk_out_d;
        logic             wrap_q, wrap_d;
        logic             wr_hit;
        logic             at_end;
        logic             commit;

        // A channel boundary is: disabled, first cycle after enable, or counter wrap.
        always_comb begin
            wr_hit = write_en && (calc_ch_q == CH_W'(i));
            at_end = (cnt_q == act_period_q - CNT_W'(1));
            commit = pend_q && (!ch_en[i] || !run_q || at_end);

            act_period_d  = commit ? pend_period_q : act_period_q;
            act_ton_d     = commit ? pend_ton_q : act_ton_q;
            pend_d        = wr_hit || (pend_q && !commit);
            pend_period_d = wr_hit ? calc_period_q : pend_period_q;
            pend_ton_d    = wr_hit ? calc_ton : pend_ton_q;
            run_d         = ch_en[i];

            if (!ch_en[i] || !run_q || at_end) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            clk_out_d = ch_en[i] && (cnt_d < act_ton_d);
            wrap_d    = ch_en[i] && (cnt_d == act_period_d - CNT_W'(1));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q         <= '0;
                act_period_q  <= CNT_W'(MIN_PERIOD);
                act_ton_q     <= '0;
                pend_period_q <= CNT_W'(MIN_PERIOD);
                pend_ton_q    <= '0;
                pend_q        <= 1'b0;
                run_q         <= 1'b0;
                clk_out_q     <= 1'b0;
                wrap_q        <= 1'b0;
            end else begin
                cnt_q         <= cnt_d;
                act_period_q  <= act_period_d;
                act_ton_q     <= act_ton_d;
                pend_period_q <= pend_period_d;
                pend_ton_q    <= pend_ton_d;
                pend_q        <= pend_d;
                run_q         <= run_d;
                clk_out_q     <= clk_out_d;
                wrap_q        <= wrap_d;
            end
        end

        assign clk_out[i] = clk_out_q;
        assign wrap[i]    = wrap_q;
    end

endmodule

// File: tb/tb_duty_gen_mc.sv
// Scoreboard bench for duty_gen_mc: stimulus queues expected per-period
// {shape_bad, period, high_count} and ready-low lengths; monitors pop and compare.
module tb_duty_gen_mc;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    typedef logic [16:0] item_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [6:0]        cfg_duty;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] wrap;

    int total = 0;
    int bad   = 0;

    item_t exp_q[2][$];
    int    ready_q[$];

    always #5 clk = ~clk;

    duty_gen_mc #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .clk_out    (clk_out),
        .wrap       (wrap)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic item_t mk(input int per, input int ton);
        return {1'b0, 8'(per), 8'(ton)};
    endfunction

    task automatic push_n(input int c, input int n, input int per, input int ton);
        for (int k = 0; k < n; k++) exp_q[c].push_back(mk(per, ton));
    endtask

    // Channel monitor: measures each full period between consecutive wrap pulses.
    int  len_c[2];
    int  hi_c[2];
    bit  primed[2];
    bit  seen_low[2];
    bit  shape_bad[2];

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_n || !ch_en[c]) begin
                primed[c] = 0; len_c[c] = 0; hi_c[c] = 0; seen_low[c] = 0; shape_bad[c] = 0;
            end else begin
                if (primed[c]) begin
                    len_c[c]++;
                    if (clk_out[c]) begin
                        hi_c[c]++;
                        if (seen_low[c]) shape_bad[c] = 1;
                    end else begin
                        seen_low[c] = 1;
                    end
                end
                if (wrap[c]) begin
                    if (primed[c] && exp_q[c].size() > 0) begin
                        item_t got;
                        item_t want;
                        got  = {shape_bad[c], 8'(len_c[c]), 8'(hi_c[c])};
                        want = exp_q[c].pop_front();
                        check($sformatf("ch%0d_period", c), 32'(got), 32'(want));
                    end
                    primed[c] = 1; len_c[c] = 0; hi_c[c] = 0; seen_low[c] = 0; shape_bad[c] = 0;
                end
            end
        end
    end

    // Ready monitor: length of each cfg_ready low stretch.
    int ready_low = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ready_low = 0;
            ready_q.delete();
        end else if (!cfg_ready) begin
            ready_low++;
        end else if (ready_low > 0) begin
            if (ready_q.size() > 0) check("ready_low_len", 32'(ready_low), 32'(ready_q.pop_front()));
            else timeout_fail("ready_low_unexpected");
            ready_low = 0;
        end
    end

    task automatic cfg_send(input int ch, input int per, input int duty, output int waited);
        cfg_ch = CH_W'(ch); cfg_period = 8'(per); cfg_duty = 7'(duty); cfg_valid = 1'b1;
        waited = 0;
        while (!cfg_ready && waited < 64) begin
            @(posedge clk); #1; waited++;
        end
        if (!cfg_ready) begin
            timeout_fail("cfg_accept");
            cfg_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            ready_q.push_back(16);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (!cfg_ready) timeout_fail("ready_return");
    endtask

    task automatic run_cfg(input int ch, input int per, input int duty);
        int w;
        cfg_send(ch, per, duty, w);
        cfg_valid = 1'b0;
        wait_ready();
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + ready_q.size()) != 0 && n < max_cyc) begin
            @(negedge clk); n++;
        end
        if ((exp_q[0].size() + exp_q[1].size() + ready_q.size()) != 0) begin
            timeout_fail("scoreboard_drain");
            exp_q[0].delete(); exp_q[1].delete(); ready_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic reconfig_ch0(input int per, input int duty, input int exp_per, input int exp_ton);
        ch_en[0] = 1'b0;
        run_cfg(0, per, duty);
        ch_en[0] = 1'b1;
        push_n(0, 2, exp_per, exp_ton);
        wait_drain(300);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        rst_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_duty = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_wrap", 32'(wrap), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(cfg_ready), 1);

        // period 10 duty 30 -> 3 high / 7 low
        run_cfg(0, 10, 30);
        ch_en[0] = 1'b1;
        push_n(0, 3, 10, 3);
        wait_drain(300);

        // valid held through a busy engine: second request waits for ready
        ch_en[0] = 1'b0;
        cfg_send(0, 10, 0, w);
        cfg_send(0, 10, 33, w);
        check("held_valid_wait", 32'(w), 16);
        cfg_valid = 1'b0;
        wait_ready();
        ch_en[0] = 1'b1;
        push_n(0, 2, 10, 3);
        wait_drain(300);

        reconfig_ch0(10, 0, 10, 0);
        reconfig_ch0(10, 120, 10, 10);
        reconfig_ch0(1, 50, 2, 1);

        // out-of-range channel is accepted and dropped
        push_n(0, 12, 2, 1);
        run_cfg(3, 10, 30);
        ch_en[1] = 1'b1;
        push_n(1, 2, 2, 0);
        wait_drain(300);

        // ch1 period 8 ton 2, rewritten to 50% mid-period
        ch_en[1] = 1'b0;
        run_cfg(1, 8, 25);
        ch_en[1] = 1'b1;
        push_n(1, 2, 8, 2);
        wait_drain(300);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!wrap[1] && n < 50);
        if (!wrap[1]) timeout_fail("ch1_wrap_wait");
        repeat (3) @(posedge clk); #1;
        push_n(0, 18, 2, 1);
        cfg_send(1, 8, 50, w);
        cfg_valid = 1'b0;
        wait_ready();
        push_n(1, 1, 8, 2);
        push_n(1, 2, 8, 4);
        wait_drain(300);

        // reset in the middle of a calculation
        cfg_send(0, 10, 30, w);
        cfg_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("calc_rst_clk_out", 32'(clk_out), 0);
        check("calc_rst_wrap", 32'(wrap), 0);
        repeat (2) @(posedge clk); #1;
        check("calc_rst_hold_clk_out", 32'(clk_out), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_calc_rst", 32'(cfg_ready), 1);
        push_n(0, 3, 2, 0);
        push_n(1, 3, 2, 0);
        wait_drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
